// File: rtl/frame_table_pkg.sv
// Shared definitions for the frame descriptor table reader: descriptor layout,
// field offsets and the reader FSM state encoding.
package frame_table_pkg;

    localparam int unsigned DESC_W        = 40;

    localparam int unsigned FRAME_ID_OFF  = 32;
    localparam int unsigned FRAME_ID_W    = 8;
    localparam int unsigned LENGTH_OFF    = 16;
    localparam int unsigned LENGTH_W      = 16;
    localparam int unsigned BASE_ADDR_OFF = 0;
    localparam int unsigned BASE_ADDR_W   = 16;

    typedef struct packed {
        logic [FRAME_ID_W-1:0]  frame_id;
        logic [LENGTH_W-1:0]    length;
        logic [BASE_ADDR_W-1:0] base_addr;
    } frame_desc_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2
    } rd_state_e;

    // A zero-length descriptor carries no payload.
    function automatic logic desc_is_empty(input frame_desc_t d);
        return d.length == '0;
    endfunction

endpackage

// File: rtl/frame_desc_skid.sv
// Two-entry valid/ready FIFO that absorbs the RAM read latency. The head entry
// drives the output directly, so data is stable while the consumer stalls.
// The producer side never pushes into a full FIFO unless a pop happens in the
// same cycle; the reader's issue logic guarantees that.
module frame_desc_skid #(
    parameter int unsigned DATA_WIDTH = 40
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [1:0][DATA_WIDTH-1:0] r_mem;
    logic                       r_head;
    logic                       r_tail;
    logic [1:0]                 r_count;
    logic                       w_pop;

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_head];
    assign w_pop   = o_valid & i_ready;

    // Storage, pointers and occupancy; clear drops contents but keeps storage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem   <= '0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else if (i_clr) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_tail] <= i_data;
                r_tail        <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/frame_table_reader.sv
// Consumer side of the frame descriptor table. Fetches descriptors in order
// from a 1-cycle-latency RAM, buffers them in a 2-entry skid FIFO and presents
// them on a valid/ready stream. Publishes the consumed count as o_rd_ptr.
// Optional feature macro: FRAME_TABLE_READER_DROP_EMPTY_EN drops zero-length
// descriptors at capture and counts them in o_drop_cnt.
module frame_table_reader
    import frame_table_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DESC_W,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [ADDR_WIDTH:0]   i_wr_ptr,
    input  logic                  i_flush,
    output logic [ADDR_WIDTH-1:0] o_ram_read_addr,
    input  logic [DATA_WIDTH-1:0] i_ram_q,
    output logic                  o_desc_valid,
    input  logic                  i_desc_ready,
    output logic [DATA_WIDTH-1:0] o_desc_data,
    output logic [ADDR_WIDTH:0]   o_rd_ptr,
    output logic [15:0]           o_drop_cnt
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0] r_wr_ptr_q;
    logic [PTR_W-1:0] r_fptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_inflight;
    rd_state_e        r_state;

    logic [PTR_W-1:0] w_fptr_d;
    logic [PTR_W-1:0] w_rd_ptr_d;
    logic             w_inflight_d;
    rd_state_e        w_state_d;

    logic [PTR_W-1:0] w_pending;
    logic [PTR_W-1:0] w_occ_next;
    logic             w_hs;
    logic             w_drop;
    logic             w_push;
    logic             w_issue;

    assign o_ram_read_addr = r_fptr[ADDR_WIDTH-1:0];
    assign o_rd_ptr        = r_rd_ptr;

    assign w_hs       = o_desc_valid & i_desc_ready;
    // Entries fetched but not yet consumed: in-flight read plus FIFO contents.
    assign w_pending  = r_fptr - r_rd_ptr;
    // FIFO occupancy after this edge, before any new issue lands.
    assign w_occ_next = w_pending - PTR_W'(w_hs) - PTR_W'(w_drop);
    assign w_push     = r_inflight & ~w_drop & ~i_flush;
    assign w_issue    = (r_state != StFlush) && !i_flush &&
                        (r_fptr != r_wr_ptr_q) && (w_occ_next < PTR_W'(2));

`ifdef FRAME_TABLE_READER_DROP_EMPTY_EN
    logic [15:0] r_drop_cnt;

    assign w_drop     = r_inflight & ~i_flush & (i_ram_q[LENGTH_OFF +: LENGTH_W] == '0);
    assign o_drop_cnt = r_drop_cnt;

    // Saturating count of zero-length descriptors discarded at capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drop_cnt <= 16'd0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end
`else
    assign w_drop     = 1'b0;
    assign o_drop_cnt = 16'd0;
`endif

    // Next-state for FSM, pointers and the in-flight read marker.
    always_comb begin
        w_state_d    = r_state;
        w_fptr_d     = r_fptr;
        w_rd_ptr_d   = r_rd_ptr + PTR_W'(w_hs) + PTR_W'(w_drop);
        w_inflight_d = w_issue;

        if (w_issue) begin
            w_fptr_d = r_fptr + PTR_W'(1);
        end

        case (r_state)
            StIdle: begin
                if (w_issue || r_inflight || o_desc_valid) begin
                    w_state_d = StRun;
                end
            end
            StRun: begin
                if (!w_issue && (w_occ_next == '0)) begin
                    w_state_d = StIdle;
                end
            end
            StFlush: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        // Flush overrides everything, including a same-cycle handshake.
        if (i_flush) begin
            w_state_d    = StFlush;
            w_fptr_d     = r_wr_ptr_q;
            w_rd_ptr_d   = r_wr_ptr_q;
            w_inflight_d = 1'b0;
        end
    end

    // State registers; wr_ptr is sampled once so a slot is never read in its write cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr_q <= '0;
            r_fptr     <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
            r_state    <= StIdle;
        end else begin
            r_wr_ptr_q <= i_wr_ptr;
            r_fptr     <= w_fptr_d;
            r_rd_ptr   <= w_rd_ptr_d;
            r_inflight <= w_inflight_d;
            r_state    <= w_state_d;
        end
    end

    frame_desc_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_flush),
        .i_push  (w_push),
        .i_data  (i_ram_q),
        .o_valid (o_desc_valid),
        .i_ready (i_desc_ready),
        .o_data  (o_desc_data)
    );

endmodule

// File: tb/tb_frame_table_reader.sv
// Directed bench for frame_table_reader with a behavioural 16-entry table RAM.
module tb_frame_table_reader;

    localparam int AW = 4;
    localparam int DW = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          desc_ready = 1'b0;
    logic [AW:0]   wr_ptr = '0;
    logic [AW-1:0] ram_read_addr;
    logic [DW-1:0] ram_q = '0;
    logic [DW-1:0] desc_data;
    logic          desc_valid;
    logic [AW:0]   rd_ptr;
    logic [15:0]   drop_cnt;

    logic [DW-1:0] mem [16];

    int n_assert = 0;
    int n_fail   = 0;
    int seq_prod = 0;
    int seq_cons = 0;
    int seq_end  = 0;

    frame_table_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_wr_ptr        (wr_ptr),
        .i_flush         (flush),
        .o_ram_read_addr (ram_read_addr),
        .i_ram_q         (ram_q),
        .o_desc_valid    (desc_valid),
        .i_desc_ready    (desc_ready),
        .o_desc_data     (desc_data),
        .o_rd_ptr        (rd_ptr),
        .o_drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    // Registered-read RAM port.
    always @(posedge clk) ram_q <= mem[ram_read_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] gen(input int k);
        logic [31:0] kk;
        kk = k;
        return {kk[7:0], kk[15:0] + 16'd1, 16'hA000 + kk[15:0]};
    endfunction

    // Producer fills free slots; consumer checks order and stall stability.
    task automatic stream(input bit rnd, input bit chk_b2b);
        logic [AW:0]   room;
        logic          stalled;
        logic [DW-1:0] held;
        bit            started;
        bit            gap;
        stalled = 1'b0;
        held    = '0;
        started = 1'b0;
        gap     = 1'b0;
        for (int cyc = 0; cyc < 600 && seq_cons < seq_end; cyc++) begin
            room = wr_ptr - rd_ptr;
            if (seq_prod < seq_end && room < 5'd16) begin
                mem[wr_ptr[AW-1:0]] = gen(seq_prod);
                wr_ptr = wr_ptr + 1'b1;
                seq_prod++;
            end
            desc_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                check("stall_valid", 64'(desc_valid), 64'd1);
                check("stall_data", 64'(desc_data), 64'(held));
            end
            stalled = 1'b0;
            if (desc_valid) begin
                started = 1'b1;
                if (desc_ready) begin
                    check("beat_data", 64'(desc_data), 64'(gen(seq_cons)));
                    seq_cons++;
                end else begin
                    stalled = 1'b1;
                    held    = desc_data;
                end
            end else if (started) begin
                gap = 1'b1;
            end
            tick();
        end
        desc_ready = 1'b0;
        check("stream_done", 64'(seq_cons), 64'(seq_end));
        if (chk_b2b) check("back_to_back_gap", 64'(gap), 64'd0);
    endtask

    // Hard stop in case something hangs outside the bounded loops.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp5 [3];
        logic [DW-1:0] got5 [4];
        int            nexp;
        int            nb;
        logic [15:0]   exp_drop;

        for (int i = 0; i < 16; i++) mem[i] = '0;

        // 1: reset values, then one entry with 3-cycle latency
        tick();
        tick();
        check("rst_valid", 64'(desc_valid), 64'd0);
        check("rst_data", 64'(desc_data), 64'd0);
        check("rst_rd_ptr", 64'(rd_ptr), 64'd0);
        check("rst_addr", 64'(ram_read_addr), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        rst_n  = 1'b1;
        mem[0] = 40'h05_0040_0100;
        wr_ptr = 5'd1;
        tick();
        tick();
        check("t1_valid_early", 64'(desc_valid), 64'd0);
        tick();
        check("t1_valid", 64'(desc_valid), 64'd1);
        check("t1_data", 64'(desc_data), 64'h05_0040_0100);
        desc_ready = 1'b1;
        tick();
        desc_ready = 1'b0;
        check("t1_rd_ptr", 64'(rd_ptr), 64'd1);
        check("t1_valid_after", 64'(desc_valid), 64'd0);

        // 2: full table of 16, back-to-back
        rst_n  = 1'b0;
        wr_ptr = '0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = gen(i);
        wr_ptr   = 5'h10;
        seq_prod = 16;
        seq_cons = 0;
        seq_end  = 16;
        stream(1'b0, 1'b1);
        tick();
        tick();
        check("t2_rd_ptr", 64'(rd_ptr), 64'h10);
        check("t2_valid_idle", 64'(desc_valid), 64'd0);

        // 3: advance to 5'h1C, then 40 entries with random ready across the wrap
        seq_end = 28;
        stream(1'b0, 1'b0);
        check("t3_start_ptr", 64'(rd_ptr), 64'h1C);
        seq_end = 68;
        stream(1'b1, 1'b0);
        tick();
        check("t3_rd_ptr", 64'(rd_ptr), 64'h04);
        check("t3_valid_idle", 64'(desc_valid), 64'd0);

        // 4: flush with two entries buffered
        mem[4] = gen(100);
        mem[5] = gen(101);
        mem[6] = gen(102);
        wr_ptr = 5'd7;
        for (int i = 0; i < 5; i++) tick();
        check("t4_pre_valid", 64'(desc_valid), 64'd1);
        check("t4_pre_data", 64'(desc_data), 64'(gen(100)));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_valid", 64'(desc_valid), 64'd0);
        check("t4_rd_ptr", 64'(rd_ptr), 64'd7);
        desc_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t4_no_stale", 64'(desc_valid), 64'd0);
        end
        check("t4_rd_ptr_hold", 64'(rd_ptr), 64'd7);

        // 5: lengths {0,8,0}
        mem[7] = {8'h21, 16'd0, 16'h0700};
        mem[8] = {8'h22, 16'd8, 16'h0800};
        mem[9] = {8'h23, 16'd0, 16'h0900};
`ifdef FRAME_TABLE_READER_DROP_EMPTY_EN
        exp5[0]  = {8'h22, 16'd8, 16'h0800};
        exp5[1]  = '0;
        exp5[2]  = '0;
        nexp     = 1;
        exp_drop = 16'd2;
`else
        exp5[0]  = {8'h21, 16'd0, 16'h0700};
        exp5[1]  = {8'h22, 16'd8, 16'h0800};
        exp5[2]  = {8'h23, 16'd0, 16'h0900};
        nexp     = 3;
        exp_drop = 16'd0;
`endif
        for (int i = 0; i < 4; i++) got5[i] = '0;
        nb         = 0;
        wr_ptr     = 5'h0A;
        desc_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (desc_valid) begin
                if (nb < 4) got5[nb] = desc_data;
                nb++;
            end
            tick();
        end
        desc_ready = 1'b0;
        check("t5_beats", 64'(nb), 64'(nexp));
        for (int i = 0; i < nexp; i++) check("t5_beat_data", 64'(got5[i]), 64'(exp5[i]));
        check("t5_rd_ptr", 64'(rd_ptr), 64'h0A);
        check("t5_drop_cnt", 64'(drop_cnt), 64'(exp_drop));

        // 6: reset mid-burst, then restart from entry 0
        for (int i = 0; i < 4; i++) mem[10 + i] = gen(200 + i);
        wr_ptr     = 5'd14;
        desc_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("t6_mid_rd_ptr", 64'(rd_ptr), 64'h0B);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(desc_valid), 64'd0);
        check("t6_rst_data", 64'(desc_data), 64'd0);
        check("t6_rst_rd_ptr", 64'(rd_ptr), 64'd0);
        check("t6_rst_addr", 64'(ram_read_addr), 64'd0);
        check("t6_rst_drop", 64'(drop_cnt), 64'd0);
        wr_ptr     = '0;
        desc_ready = 1'b0;
        tick();
        rst_n  = 1'b1;
        mem[0] = gen(300);
        wr_ptr = 5'd1;
        tick();
        tick();
        check("t6_valid_early", 64'(desc_valid), 64'd0);
        tick();
        check("t6_valid", 64'(desc_valid), 64'd1);
        check("t6_data", 64'(desc_data), 64'(gen(300)));
        desc_ready = 1'b1;
        tick();
        desc_ready = 1'b0;
        check("t6_rd_ptr", 64'(rd_ptr), 64'd1);
        check("t6_valid_after", 64'(desc_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
